// File: rtl/sc_matrix_pkg.sv
// Shared definitions for the LED-matrix frame path: mode encodings and default image.
package sc_matrix_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO_L = 2'b10,
        MODE_AUTO_R = 2'b11
    } mode_e;

    localparam int DEF_DATAWIDTH_BUS = 8;
    localparam int DEF_ROWS          = 8;

    // Row 0 is the least significant byte.
    localparam logic [63:0] DEF_INIT_FRAME = {8'h10, 8'h38, 8'h7C, 8'h7C, 8'h38, 8'h10, 8'h00, 8'h10};

    function automatic logic isAutoMode(input mode_e mode);
        return (mode == MODE_AUTO_L) || (mode == MODE_AUTO_R);
    endfunction

endpackage

// File: rtl/sc_matrix_prescaler.sv
// Free-running tick generator with clear; wrapNow marks the wrapping cycle, tick follows it one cycle later.
module sc_matrix_prescaler #(
    parameter int               WIDTH = 23,
    parameter logic [WIDTH-1:0] TOP   = 23'd5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrapNow,
    output logic tick
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST = TOP - ONE;

    logic [WIDTH-1:0] count_r;
    logic             tick_r;

    // Wrap condition: clear takes precedence over the terminal count.
    always_comb begin
        wrapNow = 1'b0;
        if (enable && !clear && (count_r == LAST)) begin
            wrapNow = 1'b1;
        end else begin
            wrapNow = 1'b0;
        end
    end

    // Counter and registered tick pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
            tick_r  <= 1'b0;
        end else if (clear || !enable) begin
            count_r <= {WIDTH{1'b0}};
            tick_r  <= 1'b0;
        end else if (wrapNow) begin
            count_r <= {WIDTH{1'b0}};
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + ONE;
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/sc_matrix_frame.sv
// Frame buffer for the MAX7219 matrix: manual/auto horizontal shift or rotate,
// transposed registered column read-out for matrix_ctrl.
module sc_matrix_frame
    import sc_matrix_pkg::*;
#(
    parameter int DATAWIDTH_BUS       = DEF_DATAWIDTH_BUS,
    parameter int ROWS                = DEF_ROWS,
    parameter int ADDR_WIDTH          = 3,
    parameter int PRESCALER_DATAWIDTH = 23,
    parameter logic [PRESCALER_DATAWIDTH-1:0] PRESCALER_TOP = 23'd5000000,
    parameter logic [ROWS*DATAWIDTH_BUS-1:0]  INIT_FRAME    = DEF_INIT_FRAME
) (
    input  logic                  sc_matrix_frame_CLOCK_50,
    input  logic                  sc_matrix_frame_RESET_InHigh,
    input  logic                  sc_matrix_frame_load_In,
    input  logic                  sc_matrix_frame_left_In,
    input  logic                  sc_matrix_frame_right_In,
    input  logic [1:0]            sc_matrix_frame_mode_In,
    input  logic                  sc_matrix_frame_wrap_In,
    input  logic [ADDR_WIDTH-1:0] sc_matrix_frame_addr_In,
    output logic [ROWS-1:0]       sc_matrix_frame_data_Out,
    output logic                  sc_matrix_frame_tick_Out,
    output logic                  sc_matrix_frame_empty_Out
);

    localparam int W  = DATAWIDTH_BUS;
    localparam int FW = ROWS * DATAWIDTH_BUS;

    mode_e             state_r;
    logic [FW-1:0]     frame_r;
    logic              leftQ_r;
    logic              rightQ_r;
    logic [ROWS-1:0]   data_r;
    logic              empty_r;

    logic              evL_s;
    logic              evR_s;
    logic              modeChange_s;
    logic              wrapNow_s;
    logic              shiftEn_s;
    logic              shiftLeft_s;
    logic [W-1:0]      rowShift_s;
    logic [ROWS-1:0]   colBits_s;

    function automatic logic [FW-1:0] shiftFrame(input logic [FW-1:0] frame,
                                                 input logic left, input logic wrap);
        logic [FW-1:0] result;
        logic [W-1:0]  row;
        result = {FW{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            row = frame[r*W +: W];
            if (left) begin
                result[r*W +: W] = {row[W-2:0], wrap ? row[W-1] : 1'b0};
            end else begin
                result[r*W +: W] = {wrap ? row[0] : 1'b0, row[W-1:1]};
            end
        end
        return result;
    endfunction

    assign evL_s        = sc_matrix_frame_left_In  & ~leftQ_r;
    assign evR_s        = sc_matrix_frame_right_In & ~rightQ_r;
    assign modeChange_s = (sc_matrix_frame_mode_In != state_r);

    sc_matrix_prescaler #(
        .WIDTH (PRESCALER_DATAWIDTH),
        .TOP   (PRESCALER_TOP)
    ) u_prescaler (
        .clk     (sc_matrix_frame_CLOCK_50),
        .rst     (sc_matrix_frame_RESET_InHigh),
        .clear   (modeChange_s),
        .enable  (isAutoMode(state_r)),
        .wrapNow (wrapNow_s),
        .tick    (sc_matrix_frame_tick_Out)
    );

    // Shift request from the current mode; simultaneous manual edges cancel.
    always_comb begin
        shiftEn_s   = 1'b0;
        shiftLeft_s = 1'b0;
        case (state_r)
            MODE_HOLD: begin
                shiftEn_s   = 1'b0;
                shiftLeft_s = 1'b0;
            end
            MODE_MANUAL: begin
                shiftEn_s   = evL_s ^ evR_s;
                shiftLeft_s = evL_s;
            end
            MODE_AUTO_L: begin
                shiftEn_s   = wrapNow_s;
                shiftLeft_s = 1'b1;
            end
            MODE_AUTO_R: begin
                shiftEn_s   = wrapNow_s;
                shiftLeft_s = 1'b0;
            end
            default: begin
                shiftEn_s   = 1'b0;
                shiftLeft_s = 1'b0;
            end
        endcase
    end

    // Transposed column: row 0 lands in the MSB; out-of-range addresses shift every bit out.
    always_comb begin
        colBits_s  = {ROWS{1'b0}};
        rowShift_s = {W{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            rowShift_s             = frame_r[r*W +: W] << sc_matrix_frame_addr_In;
            colBits_s[ROWS-1-r]    = rowShift_s[W-1];
        end
    end

    // Mode register, edge detectors, frame image and registered read-out.
    always_ff @(posedge sc_matrix_frame_CLOCK_50) begin
        if (sc_matrix_frame_RESET_InHigh) begin
            state_r  <= MODE_HOLD;
            leftQ_r  <= 1'b0;
            rightQ_r <= 1'b0;
            frame_r  <= INIT_FRAME;
            data_r   <= {ROWS{1'b0}};
            empty_r  <= (INIT_FRAME == {FW{1'b0}});
        end else begin
            state_r  <= mode_e'(sc_matrix_frame_mode_In);
            leftQ_r  <= sc_matrix_frame_left_In;
            rightQ_r <= sc_matrix_frame_right_In;
            data_r   <= colBits_s;
            empty_r  <= (frame_r == {FW{1'b0}});
            if (sc_matrix_frame_load_In) begin
                frame_r <= INIT_FRAME;
            end else if (shiftEn_s) begin
                frame_r <= shiftFrame(frame_r, shiftLeft_s, sc_matrix_frame_wrap_In);
            end else begin
                frame_r <= frame_r;
            end
        end
    end

    assign sc_matrix_frame_data_Out  = data_r;
    assign sc_matrix_frame_empty_Out = empty_r;

endmodule

// File: tb/tb_sc_matrix_frame.sv
// Directed bench for sc_matrix_frame with a per-cycle reference model of the 8x8 image.
module tb_sc_matrix_frame;

    localparam int TOP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       wrap = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] dataOut;
    logic       tickOut;
    logic       emptyOut;

    sc_matrix_frame #(
        .PRESCALER_TOP (23'd4)
    ) dut (
        .sc_matrix_frame_CLOCK_50     (clk),
        .sc_matrix_frame_RESET_InHigh (rst),
        .sc_matrix_frame_load_In      (load),
        .sc_matrix_frame_left_In      (left),
        .sc_matrix_frame_right_In     (right),
        .sc_matrix_frame_mode_In      (mode),
        .sc_matrix_frame_wrap_In      (wrap),
        .sc_matrix_frame_addr_In      (addr),
        .sc_matrix_frame_data_Out     (dataOut),
        .sc_matrix_frame_tick_Out     (tickOut),
        .sc_matrix_frame_empty_Out    (emptyOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] initV = 64'h10387C7C38100010;
    int          rows [8];
    int          mMode = 0;
    int          mPrevL = 0;
    int          mPrevR = 0;
    int          mAge = 0;       // cycles spent in the current auto mode
    int          eData = 0;
    int          eTick = 0;
    int          eEmpty = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic loadInit();
        for (int r = 0; r < 8; r++) rows[r] = int'(initV[r*8 +: 8]);
    endtask

    function automatic int column(input int a);
        int c = 0;
        for (int r = 0; r < 8; r++)
            if (a < 8 && ((rows[r] >> (7 - a)) & 1) == 1) c = c | (1 << (7 - r));
        return c;
    endfunction

    function automatic int allZero();
        int z = 1;
        for (int r = 0; r < 8; r++) if (rows[r] != 0) z = 0;
        return z;
    endfunction

    // Advance model and DUT one clock, then compare every output.
    task automatic step();
        int evL, evR, auto, change, tickNow, doShift, goLeft;
        evL     = (left  && mPrevL == 0) ? 1 : 0;
        evR     = (right && mPrevR == 0) ? 1 : 0;
        auto    = (mMode >= 2) ? 1 : 0;
        change  = (int'(mode) != mMode) ? 1 : 0;
        tickNow = (auto == 1 && change == 0 && (mAge % TOP) == TOP - 1) ? 1 : 0;
        if (rst) begin
            loadInit();
            eData = 0; eTick = 0; eEmpty = 0;
            mMode = 0; mPrevL = 0; mPrevR = 0; mAge = 0;
        end else begin
            eData  = column(int'(addr));
            eEmpty = allZero();
            eTick  = tickNow;
            doShift = 0; goLeft = 0;
            if (mMode == 1 && (evL + evR) == 1) begin doShift = 1; goLeft = evL; end
            if (mMode == 2 && tickNow == 1) begin doShift = 1; goLeft = 1; end
            if (mMode == 3 && tickNow == 1) begin doShift = 1; goLeft = 0; end
            if (load) loadInit();
            else if (doShift == 1) begin
                for (int r = 0; r < 8; r++) begin
                    if (goLeft == 1)
                        rows[r] = ((rows[r] * 2) % 256) + (wrap ? rows[r] / 128 : 0);
                    else
                        rows[r] = (rows[r] / 2) + (wrap ? (rows[r] % 2) * 128 : 0);
                end
            end
            mAge   = (change == 1 || auto == 0) ? 0 : mAge + 1;
            mMode  = int'(mode);
            mPrevL = left ? 1 : 0;
            mPrevR = right ? 1 : 0;
        end
        @(posedge clk);
        #1;
        check("data_Out", int'(dataOut), eData);
        check("tick_Out", int'(tickOut), eTick);
        check("empty_Out", int'(emptyOut), eEmpty);
    endtask

    int ticks;
    int firstTick;
    int waited;

    initial begin
        loadInit();
        // Reset
        rst = 1'b1; step(); step();
        check("reset_data", int'(dataOut), 0);
        check("reset_empty", int'(emptyOut), 0);
        rst = 1'b0;
        addr = 3'd0; step();
        check("addr0_col", int'(dataOut), 8'h00);
        addr = 3'd3; step();
        check("addr3_col", int'(dataOut), 8'hBF);
        check("idle_tick", int'(tickOut), 0);

        // Manual rotate left
        mode = 2'b01; wrap = 1'b1; step();
        left = 1'b1; step();
        check("model_row0_rotL", rows[0], 8'h20);
        check("model_row4_rotL", rows[4], 8'hF8);
        addr = 3'd2; step();
        check("addr2_after_rotL", int'(dataOut), 8'hBF);
        for (int i = 0; i < 10; i++) step();
        check("held_left_no_shift", int'(dataOut), 8'hBF);
        left = 1'b0; step();

        // Simultaneous edges cancel
        left = 1'b1; right = 1'b1; step();
        left = 1'b0; right = 1'b0; step(); step();
        check("cancel_edges", int'(dataOut), 8'hBF);

        // Shift out with zero fill
        wrap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            left = 1'b1; step();
            left = 1'b0; step();
        end
        step();
        check("shift_out_empty", int'(emptyOut), 1);
        check("shift_out_data", int'(dataOut), 8'h00);

        // Load beats a simultaneous left edge
        load = 1'b1; left = 1'b1; addr = 3'd3; step();
        load = 1'b0; left = 1'b0; step();
        check("load_col3", int'(dataOut), 8'hBF);
        check("model_row0_load", rows[0], 8'h10);
        step();
        check("load_not_empty", int'(emptyOut), 0);

        // Auto right rotate, tick every 4 cycles
        mode = 2'b11; wrap = 1'b1; ticks = 0; firstTick = 0;
        for (int i = 1; i <= 21; i++) begin
            addr = 3'(i);
            step();
            if (tickOut) begin
                ticks++;
                if (firstTick == 0) firstTick = i;
            end
        end
        check("autoR_tick_count", ticks, 5);
        check("autoR_first_tick", firstTick, 5);
        check("model_row0_autoR", rows[0], 8'h80);

        // Auto left, pause in HOLD, resume: prescaler restarts
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin addr = 3'(i); step(); end
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin addr = 3'(i + 4); step(); end
        mode = 2'b10; waited = 0;
        while (waited < 10) begin
            addr = 3'(waited);
            step();
            waited++;
            if (tickOut) break;
        end
        check("resume_first_tick", waited, 5);

        // Reset mid-scroll
        for (int i = 0; i < 2; i++) step();
        rst = 1'b1; step();
        check("midreset_data", int'(dataOut), 0);
        check("midreset_tick", int'(tickOut), 0);
        rst = 1'b0; addr = 3'd3; step();
        check("midreset_init_col3", int'(dataOut), 8'hBF);
        for (int i = 0; i < 6; i++) begin addr = 3'(i); step(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
